// File: rtl/line_fill_arbiter.sv
// Round-robin cache line fill sequencer: two requesters share one 32-bit slow memory.
// Each fill reads NW words of the line-aligned address and pulses the owner's done.
module line_fill_arbiter #(
  parameter int LW  = 512,
  parameter int OFW = $clog2(LW / 8)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          r0_start,
  input  logic [31:0]   r0_addr,
  output logic          r0_done,
  input  logic          r1_start,
  input  logic [31:0]   r1_addr,
  output logic          r1_done,
  output logic [LW-1:0] line_data,
  output logic          busy,
  output logic          grant,
  output logic          mem_req,
  output logic [31:0]   mem_addr,
  input  logic          mem_ack,
  input  logic [31:0]   mem_rdata,
  output logic [1:0]    state_dbg
);

  localparam int NW = LW / 32;
  localparam int CW = $clog2(NW);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state;
  logic [31:0]   base;
  logic [CW-1:0] cnt;
  logic          last_grant;
  logic          abandon;
  logic          next_grant;
  logic [31:0]   sel_addr;
  logic          owner_start;
  logic [31:0]   line_mask;

  // Memory handshake: mem_req/mem_addr hold steady until a cycle with mem_ack=1,
  // which completes exactly one word transfer; mem_ack without mem_req is ignored.
  always_comb begin
    busy        = (state != IDLE);
    mem_req     = (state == FETCH);
    mem_addr    = base + {{(30 - CW){1'b0}}, cnt, 2'b00};
    state_dbg   = state;
    next_grant  = (r0_start && r1_start) ? ~last_grant : r1_start;
    sel_addr    = next_grant ? r1_addr : r0_addr;
    owner_start = grant ? r1_start : r0_start;
    line_mask   = ~((32'd1 << OFW) - 32'd1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      r0_done    <= 1'b0;
      r1_done    <= 1'b0;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      base       <= 32'd0;
      cnt        <= '0;
      abandon    <= 1'b0;
      line_data  <= '0;
    end else begin
      r0_done <= 1'b0;
      r1_done <= 1'b0;
      case (state)
        IDLE: begin
          if (r0_start || r1_start) begin
            grant   <= next_grant;
            base    <= sel_addr & line_mask;
            cnt     <= '0;
            abandon <= 1'b0;
            state   <= FETCH;
          end
        end
        FETCH: begin
          // A requester that lets go mid-fill loses its done pulse, but the
          // in-flight word sequence still runs to the end.
          if (!owner_start) abandon <= 1'b1;
          if (mem_ack) begin
            line_data[{cnt, 5'd0} +: 32] <= mem_rdata;
            if (&cnt) begin
              state <= DONE;
              if (grant) r1_done <= owner_start && !abandon;
              else       r0_done <= owner_start && !abandon;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        DONE: begin
          last_grant <= grant;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
